// File: rtl/exe_stage_pkg.sv
// Shared state type and default constants for the multi-cycle execute stage.
package exe_stage_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    localparam logic [31:0] DEF_BRANCH_MAGIC = 32'hCAFEBABE;
    localparam int          DEF_RW_OPC_LSB   = 26;
    localparam int          DEF_RW_OPC_W     = 6;
    localparam int          DEF_RW_OPC_VAL   = 0;

    // Counter width able to hold LATENCY-1; never zero bits wide.
    function automatic int cnt_width(input int lat);
        return (lat > 1) ? $clog2(lat) : 1;
    endfunction

endpackage

// File: rtl/exe_latency_cnt.sv
// Loadable down-counter with zero flag; saturates at zero so it never wraps.
module exe_latency_cnt #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic         o_zero
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_cnt <= '0;
        else if (i_load)
            r_cnt <= i_load_val;
        else if (i_dec && (r_cnt != '0))
            r_cnt <= r_cnt - 1'b1;
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/exe_stage_mc.sv
// Multi-cycle execute stage: req/ack in, done/done_ack out, fixed LATENCY.
// Optional flush input enabled by defining EXE_STAGE_MC_FLUSH_EN.
module exe_stage_mc
    import exe_stage_pkg::*;
#(
    parameter int          DATA_W       = 32,
    parameter int          LATENCY      = 15,
    parameter logic [31:0] BRANCH_MAGIC = DEF_BRANCH_MAGIC,
    parameter int          RW_OPC_LSB   = DEF_RW_OPC_LSB,
    parameter int          RW_OPC_W     = DEF_RW_OPC_W,
    parameter int          RW_OPC_VAL   = DEF_RW_OPC_VAL
) (
    input  logic              clk,
    input  logic              rst_n,
`ifdef EXE_STAGE_MC_FLUSH_EN
    input  logic              flush,
`endif
    input  logic              req,
    input  logic [DATA_W-1:0] instruction,
    output logic              ack,
    output logic              done,
    input  logic              done_ack,
    output logic              qual_branch,
    output logic              qual_regwrite,
    output logic              busy
);

    localparam int                   CNT_W    = cnt_width(LATENCY);
    localparam logic [CNT_W-1:0]     CNT_LOAD = CNT_W'(LATENCY - 1);
    localparam logic [DATA_W-1:0]    MAGIC    = DATA_W'(BRANCH_MAGIC);
    localparam logic [RW_OPC_W-1:0]  OPC      = RW_OPC_W'(RW_OPC_VAL);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [DATA_W-1:0]   r_instr;
    logic                r_qual_br;
    logic                r_qual_rw;
    logic                w_flush;
    logic                w_ack;
    logic                w_accept;
    logic                w_to_hold;
    logic                w_cnt_zero;

`ifdef EXE_STAGE_MC_FLUSH_EN
    assign w_flush = flush;
`else
    assign w_flush = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ack       = 1'b0;
        w_to_hold   = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_ack = 1'b1;
                if (req)
                    w_state_nxt = S_EXEC;
            end
            S_EXEC: begin
                if (w_cnt_zero) begin
                    w_state_nxt = S_HOLD;
                    w_to_hold   = 1'b1;
                end
            end
            S_HOLD: begin
                // Consume and accept in the same cycle for zero-bubble issue.
                if (done_ack) begin
                    w_ack       = 1'b1;
                    w_state_nxt = req ? S_EXEC : S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (w_flush) begin
            w_ack       = 1'b0;
            w_to_hold   = 1'b0;
            w_state_nxt = S_IDLE;
        end
    end

    assign w_accept = req && w_ack;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_instr   <= '0;
            r_qual_br <= 1'b0;
            r_qual_rw <= 1'b0;
        end else begin
            if (w_accept)
                r_instr <= instruction;
            if (w_flush) begin
                r_qual_br <= 1'b0;
                r_qual_rw <= 1'b0;
            end else if (w_to_hold) begin
                r_qual_br <= (r_instr == MAGIC);
                r_qual_rw <= (r_instr[RW_OPC_LSB +: RW_OPC_W] == OPC);
            end
        end
    end

    exe_latency_cnt #(
        .W (CNT_W)
    ) u_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_accept),
        .i_load_val (CNT_LOAD),
        .i_dec      (r_state == S_EXEC),
        .o_zero     (w_cnt_zero)
    );

    assign ack           = w_ack;
    assign done          = (r_state == S_HOLD);
    assign busy          = (r_state != S_IDLE);
    assign qual_branch   = r_qual_br;
    assign qual_regwrite = r_qual_rw;

endmodule

// File: tb/tb_exe_stage_mc.sv
// Bench for exe_stage_mc: three instances (LATENCY 15, 1, 255) share stimulus and are
// checked every cycle against a timestamp model, plus directed literal checks.
module tb_exe_stage_mc;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic        done_ack = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] instruction = '0;
    logic [2:0]  d_ack, d_done, d_qb, d_qr, d_busy;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    // Model: an operation in flight plus the cycle count at which its result appears.
    bit          m_have[3];
    int          m_dc[3];
    logic [31:0] m_ins[3];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        exe_stage_mc #(
            .LATENCY ((g == 0) ? 15 : (g == 1) ? 1 : 255)
        ) u_dut (
            .clk           (clk),
            .rst_n         (rst_n),
`ifdef EXE_STAGE_MC_FLUSH_EN
            .flush         (flush),
`endif
            .req           (req),
            .instruction   (instruction),
            .ack           (d_ack[g]),
            .done          (d_done[g]),
            .done_ack      (done_ack),
            .qual_branch   (d_qb[g]),
            .qual_regwrite (d_qr[g]),
            .busy          (d_busy[g])
        );
    end

    function automatic int lat_of(input int k);
        return (k == 0) ? 15 : (k == 1) ? 1 : 255;
    endfunction

    function automatic bit m_done(input int k);
        return m_have[k] && (cyc >= m_dc[k]);
    endfunction

    function automatic bit m_ack(input int k);
        return (!m_have[k] || (m_done(k) && done_ack)) && !flush;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 3; k++) begin
                m_have[k] <= 1'b0;
                m_ins[k]  <= '0;
            end
        end else begin
            cyc <= cyc + 1;
            for (int k = 0; k < 3; k++) begin
                if (flush)
                    m_have[k] <= 1'b0;
                else if (req && m_ack(k)) begin
                    m_have[k] <= 1'b1;
                    m_dc[k]   <= cyc + 1 + lat_of(k);
                    m_ins[k]  <= instruction;
                end else if (m_done(k) && done_ack)
                    m_have[k] <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("ack%0d", k), int'(d_ack[k]), int'(m_ack(k)));
            chk($sformatf("done%0d", k), int'(d_done[k]), int'(m_done(k)));
            chk($sformatf("busy%0d", k), int'(d_busy[k]), int'(m_have[k]));
            if (m_done(k)) begin
                chk($sformatf("qbr%0d", k), int'(d_qb[k]), int'(m_ins[k] == 32'hCAFEBABE));
                chk($sformatf("qrw%0d", k), int'(d_qr[k]), int'(m_ins[k][31:26] == 6'd0));
            end
        end
    end

    initial begin
        int acc;
        int n;
        int first[3];
        int rise[2];
        int nr;
        bit prev;
        logic [31:0] r;

        // Reset values while held in reset
        @(negedge clk);
        chk("rst_ack", int'(d_ack[0]), 1);
        chk("rst_done", int'(d_done[0]), 0);
        chk("rst_busy", int'(d_busy[0]), 0);
        chk("rst_qbr", int'(d_qb[0]), 0);
        chk("rst_qrw", int'(d_qr[0]), 0);
        tick();
        rst_n = 1'b1;

        // Branch magic: latency from acceptance edge to first done
        tick();
        req = 1'b1;
        instruction = 32'hCAFEBABE;
        tick();
        acc = cyc;
        req = 1'b0;
        first = '{-1, -1, -1};
        repeat (260) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++)
                if (d_done[k] && first[k] < 0) first[k] = cyc;
        end
        chk("lat15", first[0] - acc, 15);
        chk("lat1", first[1] - acc, 1);
        chk("lat255", first[2] - acc, 255);
        chk("magic_qbr", int'(d_qb[0]), 1);
        chk("magic_qrw", int'(d_qr[0]), 0);

        // Zero-bubble consume+accept of an opcode-0 instruction, then hold 5 cycles
        tick();
        req = 1'b1;
        done_ack = 1'b1;
        instruction = 32'h0000_1234;
        tick();
        done_ack = 1'b0;
        n = 0;
        while (!d_done[0] && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("hold_reached", int'(d_done[0]), 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_done", int'(d_done[0]), 1);
            chk("hold_qrw", int'(d_qr[0]), 1);
            chk("hold_qbr", int'(d_qb[0]), 0);
            chk("hold_ack", int'(d_ack[0]), 0);
        end

        // Back-to-back: req and done_ack held high; 15 idle-done cycles between pulses
        tick();
        done_ack = 1'b1;
        req = 1'b1;
        prev = 1'b1;
        nr = 0;
        rise = '{0, 0};
        repeat (50) begin
            @(negedge clk);
            if (d_done[0] && !prev && nr < 2) begin
                rise[nr] = cyc;
                nr++;
            end
            prev = d_done[0];
        end
        chk("b2b_pulses", nr, 2);
        chk("b2b_gap", rise[1] - rise[0] - 1, 15);

        // Drain to idle
        tick();
        req = 1'b0;
        n = 0;
        while (d_busy[0] && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("drain_idle", int'(d_busy[0]), 0);
        tick();
        done_ack = 1'b0;

        // Reset during the 7th execute cycle discards the operation
        req = 1'b1;
        instruction = 32'h0000_0001;
        tick();
        req = 1'b0;
        repeat (6) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("mid_rst_ack", int'(d_ack[0]), 1);
        chk("mid_rst_done", int'(d_done[0]), 0);
        chk("mid_rst_busy", int'(d_busy[0]), 0);
        chk("mid_rst_qrw", int'(d_qr[0]), 0);
        tick();
        rst_n = 1'b1;
        n = 0;
        repeat (30) begin
            @(negedge clk);
            if (d_done != 3'b000) n++;
        end
        chk("post_rst_no_done", n, 0);
        chk("post_rst_ack", int'(d_ack[0]), 1);

`ifdef EXE_STAGE_MC_FLUSH_EN
        // Flush in HOLD with req high: idle next cycle, no acceptance
        tick();
        req = 1'b1;
        instruction = 32'hCAFEBABE;
        tick();
        req = 1'b0;
        n = 0;
        while (!d_done[0] && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("fl_hold", int'(d_done[0]), 1);
        tick();
        req = 1'b1;
        flush = 1'b1;
        @(negedge clk);
        chk("fl_ack", int'(d_ack[0]), 0);
        tick();
        flush = 1'b0;
        req = 1'b0;
        @(negedge clk);
        chk("fl_done", int'(d_done[0]), 0);
        chk("fl_busy", int'(d_busy[0]), 0);
        chk("fl_qbr", int'(d_qb[0]), 0);
`endif

        // Randomized traffic, occasional reset (and flush when present)
        for (int i = 0; i < 4000; i++) begin
            tick();
            rst_n = ($urandom_range(0, 499) != 0);
            req = ($urandom_range(0, 2) != 0);
            done_ack = ($urandom_range(0, 3) != 0);
`ifdef EXE_STAGE_MC_FLUSH_EN
            flush = ($urandom_range(0, 39) == 0);
`endif
            r = $urandom;
            case ($urandom_range(0, 2))
                0: instruction = 32'hCAFEBABE;
                1: instruction = r & 32'h03FF_FFFF;
                default: instruction = r;
            endcase
        end
        tick();
        rst_n = 1'b1;
        req = 1'b0;
        flush = 1'b0;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
